// File: rtl/udp_pkg.sv
// Shared types and default constants for the UDP JPEG packet scheduler.
package udp_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5,
    S_DONE      = 3'd6
  } sched_state_t;

  localparam int unsigned DEF_MAX_PAYLOAD    = 1024;
  localparam int unsigned DEF_GAP_CYCLES     = 100;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;

  // Payload of the next packet: whatever is left, capped at the maximum.
  function automatic logic [15:0] pkt_len_of(input logic [23:0] rem, input logic [23:0] max_len);
    return (rem <= max_len) ? rem[15:0] : max_len[15:0];
  endfunction

endpackage

// File: rtl/udp_watchdog.sv
// Per-packet cycle watchdog: counts while enabled, pulses expire on the LIMIT-th cycle.
module udp_watchdog #(
  parameter int unsigned LIMIT = 65535
)(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_en && !o_expire) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_en && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/udp_jpeg_pkt_sched.sv
// Splits a JPEG frame into UDP packet descriptors and paces them to a 128-bit sender.
module udp_jpeg_pkt_sched
  import udp_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD    = DEF_MAX_PAYLOAD,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
  input  logic        i_udp_clk50m,
  input  logic        i_rst,
  input  logic        i_frame_valid,
  input  logic [23:0] i_frame_len,
  output logic        o_frame_ready,
  output logic        o_frame_done,
  output logic        o_send_en,
  output logic [15:0] o_pkt_len,
  output logic [14:0] o_pkt_rank,
  output logic        o_last_flag,
  output logic [15:0] o_ipv4_sign,
  output logic [23:0] o_pkt_offset,
  input  logic        i_send_busy,
  input  logic        i_send_frame_down,
  output logic [2:0]  o_state,
  output logic        o_err_timeout
);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  sched_state_t  r_state, w_next;
  logic [23:0]   r_remaining;
  logic [15:0]   r_pkt_len;
  logic [14:0]   r_pkt_rank;
  logic          r_last_flag;
  logic [15:0]   r_ipv4_sign;
  logic [23:0]   r_pkt_offset;
  logic [GW-1:0] r_gap_cnt;
  logic          r_fd_d, r_fd_seen;
  logic          w_ready, w_wait, w_expire, w_pkt_done;

  assign w_ready    = (r_state == S_IDLE) && !i_rst;
  assign w_wait     = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  assign w_pkt_done = (r_state == S_WAIT_DONE) && !i_send_busy && !w_expire;

  udp_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .i_clk    (i_udp_clk50m),
    .i_rst    (i_rst),
    .i_clr    (!w_wait),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (i_frame_valid && w_ready) w_next = S_LOAD;
      S_LOAD:      w_next = (r_remaining == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:     w_next = S_WAIT_BUSY;
      // A latched done edge also releases WAIT_BUSY, for senders too quick to show busy.
      S_WAIT_BUSY: if (w_expire) w_next = S_DONE;
                   else if (i_send_busy || r_fd_seen) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (w_expire) w_next = S_DONE;
                   else if (!i_send_busy) w_next = r_last_flag ? S_DONE : S_GAP;
      S_GAP:       if (r_gap_cnt == GW'(GAP_CYCLES - 1)) w_next = S_LOAD;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_udp_clk50m) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_pkt_len    <= '0;
      r_pkt_rank   <= '0;
      r_last_flag  <= 1'b0;
      r_ipv4_sign  <= '0;
      r_pkt_offset <= '0;
      r_gap_cnt    <= '0;
      r_fd_d       <= 1'b0;
      r_fd_seen    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_fd_d    <= i_send_frame_down;
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      if (r_state == S_ISSUE) r_fd_seen <= 1'b0;
      else if (i_send_frame_down && !r_fd_d) r_fd_seen <= 1'b1;
      if (r_state == S_IDLE && i_frame_valid) begin
        r_remaining  <= i_frame_len;
        r_pkt_offset <= '0;
        r_pkt_rank   <= '0;
      end
      if (r_state == S_LOAD && r_remaining != '0) begin
        r_pkt_len   <= pkt_len_of(r_remaining, 24'(MAX_PAYLOAD));
        r_last_flag <= (r_remaining <= 24'(MAX_PAYLOAD));
      end
      if (w_pkt_done) begin
        r_remaining  <= r_remaining - {8'd0, r_pkt_len};
        r_pkt_offset <= r_pkt_offset + {8'd0, r_pkt_len};
        r_pkt_rank   <= r_pkt_rank + 1'b1;
      end
      // Sequence numbers are consumed by aborted packets too and never cleared per frame.
      if (w_pkt_done || w_expire) r_ipv4_sign <= r_ipv4_sign + 1'b1;
    end
  end

  assign o_frame_ready = w_ready;
  assign o_send_en     = (r_state == S_ISSUE) && !i_rst;
  assign o_frame_done  = (r_state == S_DONE) && !i_rst;
  assign o_err_timeout = w_expire && !i_rst;
  assign o_pkt_len     = r_pkt_len;
  assign o_pkt_rank    = r_pkt_rank;
  assign o_last_flag   = r_last_flag;
  assign o_ipv4_sign   = r_ipv4_sign;
  assign o_pkt_offset  = r_pkt_offset;
  assign o_state       = r_state;

endmodule
